e_mem_arb: RTL and testbench

//  Two-requester scheduler for the shared BRAM address port. Each requester keeps its own

---
 rtl/e_mem_pkg.sv | 17 +
 rtl/e_mem_ptr.sv | 37 +++
 rtl/e_mem_arb.sv | 127 ++++++++++++
 tb/tb_e_mem_arb.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/e_mem_pkg.sv
// e_mem_pkg: shared defaults and FSM state type for the BRAM address-port arbiter.
package e_mem_pkg;

  localparam int ADDR_W_DEF    = 18;
  localparam int ADDR_MAX_DEF  = 262143;
  localparam int WRAP_BASE_DEF = 259072;
  localparam int HOLD_ADDR_DEF = 2048;
  localparam int BURST_LEN_DEF = 16;
  localparam int BLEN_W_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/e_mem_ptr.sv
// e_mem_ptr: one requester's address pointer. Advances by one per issued beat,
// jumps from ADDR_MAX back to WRAP_BASE, and flags when it sits on HOLD_ADDR.
module e_mem_ptr
  import e_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ADDR_MAX  = ADDR_MAX_DEF,
  parameter int WRAP_BASE = WRAP_BASE_DEF,
  parameter int HOLD_ADDR = HOLD_ADDR_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              adv,
  input  logic              hold,
  output logic [ADDR_W-1:0] ptr,
  output logic              at_hold
);

  localparam logic [ADDR_W-1:0] MAX_V  = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W-1:0] WRAP_V = ADDR_W'(WRAP_BASE);
  localparam logic [ADDR_W-1:0] HOLD_V = ADDR_W'(HOLD_ADDR);

  // Ring successor: the only jump a pointer ever makes is ADDR_MAX -> WRAP_BASE.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    if (p == MAX_V) next_ptr = WRAP_V;
    else            next_ptr = p + ADDR_W'(1);
  endfunction

  assign at_hold = (ptr == HOLD_V);

  // Pointer register: hold has priority, so a HOLD_ADDR equal to ADDR_MAX freezes before wrapping.
  always_ff @(posedge CLK) begin
    if (rst)              ptr <= '0;
    else if (adv && !hold) ptr <= next_ptr(ptr);
  end

endmodule

// File: rtl/e_mem_arb.sv
// e_mem_arb: two-requester burst scheduler for the shared BRAM address port.
// Each grant is a fixed BURST_LEN-beat burst driven from the owner's own pointer.
// Build option: define E_MEM_ARB_PRIO_EN for fixed priority (req[0] always wins);
// otherwise contention is resolved round-robin against the last owner.
module e_mem_arb
  import e_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ADDR_MAX  = ADDR_MAX_DEF,
  parameter int WRAP_BASE = WRAP_BASE_DEF,
  parameter int HOLD_ADDR = HOLD_ADDR_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int BLEN_W    = BLEN_W_DEF
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic              stall,
  output logic [1:0]        gnt,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic              owner,
  output logic [1:0]        done,
  output logic              busy
);

  localparam logic [BLEN_W-1:0] LAST_BEAT = BLEN_W'(BURST_LEN - 1);

  state_t            state;
  logic [BLEN_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] ptr0;
  logic [ADDR_W-1:0] ptr1;
  logic              at_hold0;
  logic              at_hold1;
  logic              cur_hold;
  logic              beat;
  logic              winner;

  // A beat is lost only when the owner's pointer is parked on HOLD_ADDR under stall.
  assign cur_hold    = stall && (owner ? at_hold1 : at_hold0);
  assign beat        = (state == BURST) && !cur_hold;
  assign mem_en      = beat;
  assign mem_address = owner ? ptr1 : ptr0;

`ifdef E_MEM_ARB_PRIO_EN
  assign winner = !req[0];
`else
  logic rr_last;
  assign winner = (req == 2'b11) ? !rr_last : req[1];
`endif

  e_mem_ptr #(
    .ADDR_W   (ADDR_W),
    .ADDR_MAX (ADDR_MAX),
    .WRAP_BASE(WRAP_BASE),
    .HOLD_ADDR(HOLD_ADDR)
  ) u_ptr0 (
    .CLK    (CLK),
    .rst    (rst),
    .adv    (beat && (owner == 1'b0)),
    .hold   (stall && at_hold0),
    .ptr    (ptr0),
    .at_hold(at_hold0)
  );

  e_mem_ptr #(
    .ADDR_W   (ADDR_W),
    .ADDR_MAX (ADDR_MAX),
    .WRAP_BASE(WRAP_BASE),
    .HOLD_ADDR(HOLD_ADDR)
  ) u_ptr1 (
    .CLK    (CLK),
    .rst    (rst),
    .adv    (beat && (owner == 1'b1)),
    .hold   (stall && at_hold1),
    .ptr    (ptr1),
    .at_hold(at_hold1)
  );

  // Burst FSM with registered gnt/done/busy; reset abandons any burst without a done pulse.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      beat_cnt <= '0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      busy     <= 1'b0;
`ifndef E_MEM_ARB_PRIO_EN
      rr_last  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 2'b00;
          if (req != 2'b00) begin
            owner    <= winner;
            beat_cnt <= '0;
            gnt      <= winner ? 2'b10 : 2'b01;
            busy     <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            beat_cnt <= beat_cnt + BLEN_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              state <= DONE;
              gnt   <= 2'b00;
              done  <= owner ? 2'b10 : 2'b01;
            end
          end
        end
        DONE: begin
          done    <= 2'b00;
          busy    <= 1'b0;
          state   <= IDLE;
`ifndef E_MEM_ARB_PRIO_EN
          rr_last <= owner;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mem_arb.sv
// tb_e_mem_arb: scoreboard bench. dut_a uses default geometry with HOLD_ADDR=5,
// dut_b a small ring (ADDR_MAX=19, WRAP_BASE=12, BURST_LEN=4).
module tb_e_mem_arb;
  import e_mem_pkg::*;

  logic        CLK = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1;
  logic [1:0]  req_a = 2'b00, req_b = 2'b00;
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [1:0]  gnt_a, gnt_b, done_a, done_b;
  logic        en_a, en_b, owner_a, owner_b, busy_a, busy_b;
  logic [17:0] addr_a, addr_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0[2];
  int last_done[2];
  int done_cnt[2];
  logic [18:0] qb[2][$];
  logic [1:0]  qd[2][$];

  e_mem_arb #(.HOLD_ADDR(5)) dut_a (
    .CLK(CLK), .rst(rst_a), .req(req_a), .stall(stall_a), .gnt(gnt_a), .mem_en(en_a),
    .mem_address(addr_a), .owner(owner_a), .done(done_a), .busy(busy_a)
  );

  e_mem_arb #(.ADDR_MAX(19), .WRAP_BASE(12), .HOLD_ADDR(100), .BURST_LEN(4)) dut_b (
    .CLK(CLK), .rst(rst_b), .req(req_b), .stall(stall_b), .gnt(gnt_b), .mem_en(en_b),
    .mem_address(addr_b), .owner(owner_b), .done(done_b), .busy(busy_b)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats / done pulses whenever a DUT presents one.
  always @(negedge CLK) begin
    logic        en, ow;
    logic [1:0]  g, d;
    logic [17:0] ad;
    logic [18:0] e;
    logic [1:0]  ed;
    for (int s = 0; s < 2; s++) begin
      en = (s == 0) ? en_a : en_b;
      ow = (s == 0) ? owner_a : owner_b;
      g  = (s == 0) ? gnt_a : gnt_b;
      d  = (s == 0) ? done_a : done_b;
      ad = (s == 0) ? addr_a : addr_b;
      if (en) begin
        if (qb[s].size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected dut=%0d actual addr=%0d required=no beat", s, ad);
        end else begin
          e = qb[s].pop_front();
          chk($sformatf("beat_addr%0d", s), 32'(ad), 32'(e[17:0]));
          chk($sformatf("beat_owner%0d", s), 32'(ow), 32'(e[18]));
          chk($sformatf("beat_gnt%0d", s), 32'(g), e[18] ? 32'd2 : 32'd1);
        end
      end
      if (d != 2'b00) begin
        done_cnt[s]++;
        last_done[s] = cyc;
        if (qd[s].size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected dut=%0d actual=%0d required=no pulse", s, d);
        end else begin
          ed = qd[s].pop_front();
          chk($sformatf("done%0d", s), 32'(d), 32'(ed));
        end
      end
    end
  end

  task automatic push_beats(input int s, input logic ow, input int start, input int n);
    for (int i = 0; i < n; i++) qb[s].push_back({ow, 18'(start + i)});
  endtask

  task automatic pulse(input int s, input logic [1:0] r);
    @(posedge CLK); #1;
    if (s == 0) req_a = r; else req_b = r;
    t0[s] = cyc;
    @(posedge CLK); #1;
    if (s == 0) req_a = 2'b00; else req_b = 2'b00;
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    do begin
      @(negedge CLK); n++;
    end while ((((s == 0) ? busy_a : busy_b) || qb[s].size() != 0 || qd[s].size() != 0) && n < 300);
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL idle_timeout dut=%0d actual=busy required=idle", s);
    end
  endtask

  task automatic wait_beat_a(input logic [17:0] a);
    int n = 0;
    do begin
      @(negedge CLK); n++;
    end while (!(en_a && addr_a == a) && n < 100);
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL beat_timeout actual=none required=%0d", a);
    end
  endtask

  task automatic reset_a();
    @(posedge CLK); #1 rst_a = 1'b1;
    @(posedge CLK); #1 rst_a = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    repeat (2) @(posedge CLK);
    #1 rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    @(negedge CLK);
    chk("rst_gnt", 32'(gnt_a), 0);
    chk("rst_mem_en", 32'(en_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_owner", 32'(owner_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_busy", 32'(busy_a), 0);

    // Single-cycle request: 16 beats from 0, done in cycle 17
    push_beats(0, 1'b0, 0, 16); qd[0].push_back(2'b01);
    pulse(0, 2'b01);
    chk("first_gnt", 32'(gnt_a), 1);
    chk("first_en", 32'(en_a), 1);
    chk("first_addr", 32'(addr_a), 0);
    wait_idle(0);
    chk("done_latency", 32'(last_done[0] - t0[0]), 17);
    // Second burst continues at 16; stall away from HOLD_ADDR changes nothing
    stall_a = 1'b1;
    push_beats(0, 1'b0, 16, 16); qd[0].push_back(2'b01);
    pulse(0, 2'b01);
    wait_idle(0);
    chk("stall_nohold_latency", 32'(last_done[0] - t0[0]), 17);
    stall_a = 1'b0;

    // Both requesting: alternate grants
    reset_a();
`ifdef E_MEM_ARB_PRIO_EN
    push_beats(0, 1'b0, 0, 48);
    repeat (3) qd[0].push_back(2'b01);
`else
    push_beats(0, 1'b0, 0, 16); push_beats(0, 1'b1, 0, 16); push_beats(0, 1'b0, 16, 16);
    qd[0].push_back(2'b01); qd[0].push_back(2'b10); qd[0].push_back(2'b01);
`endif
    base = done_cnt[0];
    @(posedge CLK); #1 req_a = 2'b11;
    n = 0;
    do begin
      @(negedge CLK); n++;
    end while (done_cnt[0] < base + 2 && n < 200);
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL rr_timeout actual=%0d required=%0d", done_cnt[0] - base, 2);
    end
    @(posedge CLK); @(posedge CLK); #1 req_a = 2'b00;
    wait_idle(0);
    chk("rr_done_count", 32'(done_cnt[0] - base), 3);

    // Hold at HOLD_ADDR=5 for three cycles
    reset_a();
    push_beats(0, 1'b0, 0, 16); qd[0].push_back(2'b01);
    pulse(0, 2'b01);
    wait_beat_a(18'd4);
    @(posedge CLK); #1 stall_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("hold_en", 32'(en_a), 0);
      chk("hold_addr", 32'(addr_a), 5);
      chk("hold_gnt", 32'(gnt_a), 1);
    end
    @(posedge CLK); #1 stall_a = 1'b0;
    wait_idle(0);
    chk("hold_done_latency", 32'(last_done[0] - t0[0]), 20);

    // Reset at the 8th beat: burst abandoned, no done, restart from 0
    reset_a();
    push_beats(0, 1'b0, 0, 8);
    base = done_cnt[0];
    pulse(0, 2'b01);
    wait_beat_a(18'd6);
    @(posedge CLK); #1 rst_a = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_gnt", 32'(gnt_a), 0);
    chk("midrst_en", 32'(en_a), 0);
    chk("midrst_addr", 32'(addr_a), 0);
    chk("midrst_done", 32'(done_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    rst_a = 1'b0;
    repeat (3) @(posedge CLK);
    chk("midrst_no_done", 32'(done_cnt[0] - base), 0);
    push_beats(0, 1'b0, 0, 16); qd[0].push_back(2'b01);
    pulse(0, 2'b01);
    wait_idle(0);

    // Small ring: six bursts of four, wrap 19 -> 12
    for (int b = 0; b < 6; b++) begin
      push_beats(1, 1'b0, (b < 5) ? 4 * b : 12, 4);
      qd[1].push_back(2'b01);
      pulse(1, 2'b01);
      wait_idle(1);
    end

    chk("beats_left_a", 32'(qb[0].size()), 0);
    chk("beats_left_b", 32'(qb[1].size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
